// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: walks a PC over a cs/oe memory with an asynchronous read,
// buffers returned words in a show-ahead prefetch FIFO. Optional halt decode: FETCH_HALT_EN.
module fetch_unit #(
  parameter int DATA_WIDTH  = 18,
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 2,
  parameter int WAIT_STATES = 1,
  parameter int RESET_PC    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_oe,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [CW-1:0]         count_q, count_d;
  logic [EW-1:0]         fifo_q [DEPTH];
  logic                  bus_en_q;
  logic                  push, pop, halt_word;
  int                    wr_idx;
  int                    count_after;

`ifdef FETCH_HALT_EN
  assign halt_word = (mem_data[DATA_WIDTH-1 -: 4] == 4'b1111);
`else
  assign halt_word = 1'b0;
`endif

  // Handshake: the head word transfers on any edge where instr_valid && instr_ready;
  // a redirect on that edge wins and the transfer does not happen.
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = (count_q != '0);
  assign instr_data  = fifo_q[0][DATA_WIDTH-1:0];
  assign instr_pc    = fifo_q[0][EW-1:DATA_WIDTH];
  assign mem_addr    = pc_q;
  assign mem_cs      = bus_en_q;
  assign mem_oe      = bus_en_q;
  assign mem_we      = 1'b0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wait_d      = wait_q;
    push        = 1'b0;
    count_after = int'(count_q) + 1 - (pop ? 1 : 0);
    if (redirect_valid) begin
      state_d = IDLE;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            state_d = ACCESS;
            wait_d  = WW'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (wait_q != '0) begin
            wait_d = wait_q - WW'(1);
          end else begin
            push = 1'b1;
            pc_d = pc_q + ADDR_WIDTH'(1);
            if (halt_word) begin
              state_d = HALTED;
            end else if (count_after < DEPTH) begin
              wait_d = WW'(WAIT_STATES);
            end else begin
              state_d = IDLE;
            end
          end
        end
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
    wr_idx = int'(count_q) - (pop ? 1 : 0);
    if (redirect_valid) count_d = '0;
    else                count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= ADDR_WIDTH'(RESET_PC);
      wait_q   <= '0;
      count_q  <= '0;
      bus_en_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      bus_en_q <= (state_d == ACCESS);
      // Shift on pop, then the push lands in the first free slot after the shift.
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) fifo_q[i] <= fifo_q[i+1];
      end
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == wr_idx) fifo_q[i] <= {pc_q, mem_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven start-up vectors plus hand-written
// redirect, halt/stream and asynchronous-reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_addr;
  logic        mem_cs, mem_oe, mem_we;
  logic [17:0] mem_data;
  logic        instr_valid;
  logic [17:0] instr_data;
  logic [3:0]  instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;

  logic [17:0] mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ready;
    logic        cs;
    logic [3:0]  addr;
    logic        valid;
    logic [17:0] data;
    logic [3:0]  pc;
  } vec_t;

  vec_t vecs [9];

  fetch_unit #(
    .DATA_WIDTH(18), .ADDR_WIDTH(4), .DEPTH(2), .WAIT_STATES(1), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  function automatic logic [17:0] word_at(input int a);
    case (a)
      0:       return 18'h1B04A;
      1:       return 18'h2C000;
      2:       return 18'h3C000;
      default: return 18'(a);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic [3:0] addr);
    check({tag, " cs"}, 32'(mem_cs), 32'(cs));
    check({tag, " oe"}, 32'(mem_oe), 32'(cs));
    check({tag, " we"}, 32'(mem_we), 32'd0);
    check({tag, " addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic check_head(input string tag, input logic valid, input logic [17:0] data,
                            input logic [3:0] pc);
    check({tag, " valid"}, 32'(instr_valid), 32'(valid));
    if (valid) begin
      check({tag, " data"}, 32'(instr_data), 32'(data));
      check({tag, " pc"}, 32'(instr_pc), 32'(pc));
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [3:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int got;
    int exp_pc;
    for (int k = 0; k < 16; k++) mem[k] = word_at(k);

    vecs[0] = '{1'b0, 1'b1, 4'd0, 1'b0, 18'h00000, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 4'd0, 1'b0, 18'h00000, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 4'd1, 1'b1, 18'h1B04A, 4'd0};
    vecs[3] = '{1'b0, 1'b1, 4'd1, 1'b1, 18'h1B04A, 4'd0};
    vecs[4] = '{1'b0, 1'b0, 4'd2, 1'b1, 18'h1B04A, 4'd0};
    vecs[5] = '{1'b0, 1'b0, 4'd2, 1'b1, 18'h1B04A, 4'd0};
    vecs[6] = '{1'b1, 1'b0, 4'd2, 1'b1, 18'h2C000, 4'd1};
    vecs[7] = '{1'b1, 1'b1, 4'd2, 1'b0, 18'h00000, 4'd0};
    vecs[8] = '{1'b1, 1'b1, 4'd2, 1'b0, 18'h00000, 4'd0};

    // Reset values while reset is held
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    #2;
    check_bus("reset", 1'b0, 4'd0);
    check("reset valid", 32'(instr_valid), 32'd0);
    check("reset data", 32'(instr_data), 32'd0);
    check("reset pc", 32'(instr_pc), 32'd0);
    step();
    rst = 1'b0;

    // Start-up sequence, one vector per edge after reset release
    for (int i = 0; i < 9; i++) begin
      instr_ready = vecs[i].ready;
      step();
      check_bus($sformatf("edge%0d", i + 1), vecs[i].cs, vecs[i].addr);
      check_head($sformatf("edge%0d", i + 1), vecs[i].valid, vecs[i].data, vecs[i].pc);
    end

`ifdef FETCH_HALT_EN
    // 0x3C000 carries the halt opcode: pushed, then fetching stops
    step();
    check_bus("halt capture", 1'b0, 4'd3);
    check_head("halt capture", 1'b1, 18'h3C000, 4'd2);
    for (int i = 0; i < 20; i++) begin
      step();
      check("halted cs", 32'(mem_cs), 32'd0);
      check("halted oe", 32'(mem_oe), 32'd0);
      check("halted valid", 32'(instr_valid), 32'd0);
    end
    pulse_redirect(4'd0);
    check_bus("halt redirect", 1'b0, 4'd0);
    step();
    check_bus("halt restart", 1'b1, 4'd0);
    step();
    step();
    check_head("halt restart word", 1'b1, 18'h1B04A, 4'd0);
`else
    // Continuous stream with instr_ready high: in order, wraps, bus never idles
    got    = 0;
    exp_pc = 2;
    for (int i = 0; i < 36; i++) begin
      step();
      check("stream cs", 32'(mem_cs), 32'd1);
      if (instr_valid) begin
        check("stream data", 32'(instr_data), 32'(word_at(exp_pc)));
        check("stream pc", 32'(instr_pc), 32'(exp_pc));
        exp_pc = (exp_pc + 1) % 16;
        got++;
      end
    end
    check("stream word count", 32'(got), 32'd18);
`endif

    // Redirect in ACCESS with one entry buffered
    do_reset();
    repeat (3) step();
    check_head("pre-redirect", 1'b1, 18'h1B04A, 4'd0);
    pulse_redirect(4'd9);
    check_bus("redirect idle", 1'b0, 4'd9);
    check("redirect flush valid", 32'(instr_valid), 32'd0);
    step();
    check_bus("redirect access", 1'b1, 4'd9);
    check("redirect still empty", 32'(instr_valid), 32'd0);
    step();
    check("redirect wait valid", 32'(instr_valid), 32'd0);
    step();
    check_head("redirect word", 1'b1, 18'h00009, 4'd9);

    // Redirect on a capture edge that also pops
    do_reset();
    repeat (4) step();
    check_head("coincide pre", 1'b1, 18'h1B04A, 4'd0);
    instr_ready = 1'b1;
    pulse_redirect(4'd12);
    check_bus("coincide idle", 1'b0, 4'd12);
    check("coincide flushed", 32'(instr_valid), 32'd0);
    step();
    check_bus("coincide access", 1'b1, 4'd12);
    step();
    step();
    check_head("coincide word", 1'b1, 18'h0000C, 4'd12);

    // Reset in the middle of an access takes effect without a clock edge
    do_reset();
    instr_ready = 1'b0;
    repeat (4) step();
    check("mid pre cs", 32'(mem_cs), 32'd1);
    check("mid pre valid", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_bus("async reset", 1'b0, 4'd0);
    check("async reset valid", 32'(instr_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check_bus("after reset edge1", 1'b1, 4'd0);
    step();
    step();
    check_head("after reset edge3", 1'b1, 18'h1B04A, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
